// File: rtl/w_shift_seq_pkg.sv
// ----------------------------------------------------------------------------
// w_shift_seq_pkg
// Shared definitions for the w_shift_seq command sequencer:
//   - command op codes carried on CMD_OP
//   - mode codes driven on S toward the W_74HC194 stage
//   - sequencer state encoding
// ----------------------------------------------------------------------------
package w_shift_seq_pkg;

    // Command op codes
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_ROR  = 2'b11;

    // W_74HC194 mode select values
    localparam logic [1:0] S_HOLD  = 2'b00;
    localparam logic [1:0] S_SHR   = 2'b01;
    localparam logic [1:0] S_SHL   = 2'b10;
    localparam logic [1:0] S_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/w_74hc194.sv
// ----------------------------------------------------------------------------
// W_74HC194
// 4-bit universal shift register (74HC194 behaviour), the stage driven by
// w_shift_seq.
//   CLK   : clock, rising edge
//   MR_N  : asynchronous active-low master reset (clears OUT)
//   S     : mode, 00 hold / 01 shift right / 10 shift left / 11 parallel load
//   D     : D[1] serial input for right shift (enters OUT[0]),
//           D[0] serial input for left shift (enters OUT[3])
//   IN    : parallel load data
//   OUT   : register contents
// ----------------------------------------------------------------------------
module W_74HC194 (
    input  logic       CLK,
    input  logic       MR_N,
    input  logic [1:0] S,
    input  logic [1:0] D,
    input  logic [0:3] IN,
    output logic [0:3] OUT
);

    always_ff @(posedge CLK or negedge MR_N) begin
        if (!MR_N) begin
            OUT <= '0;
        end else begin
            case (S)
                2'b01:   OUT <= {D[1], OUT[0:2]};
                2'b10:   OUT <= {OUT[1:3], D[0]};
                2'b11:   OUT <= IN;
                default: OUT <= OUT;
            endcase
        end
    end

endmodule

// File: rtl/w_shift_seq.sv
// ----------------------------------------------------------------------------
// w_shift_seq
// Command sequencer upstream of a W_74HC194 universal shift register. One
// command is accepted per CMD_VALID/CMD_READY handshake (load, or N-step
// left/right shift with a fill bit) and is played out on S/D/IN cycle by
// cycle. DONE pulses for one cycle when the command has finished.
//
// Optional feature: define SEQ_ROTATE_EN to make op 11 a rotate-right of
// CMD_CNT steps (D[1] fed from Q[3]). Without it op 11 is an accepted no-op
// and Q is not used.
//
// Ports:
//   CLK        : clock, rising edge
//   MR_N       : asynchronous active-low reset (shared with W_74HC194)
//   CMD_VALID  : command present           CMD_READY : accepting (IDLE only)
//   CMD_OP     : 00 load, 01 shr, 10 shl, 11 rotate right / no-op
//   CMD_FILL   : serial fill bit           CMD_CNT   : shift step count
//   CMD_DATA   : parallel load value       Q         : W_74HC194 OUT feedback
//   S, D, IN   : mode / serial / parallel inputs of W_74HC194
//   BUSY       : command in progress       DONE      : completion pulse
// ----------------------------------------------------------------------------
module w_shift_seq
    import w_shift_seq_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             MR_N,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic             CMD_FILL,
    input  logic [CNT_W-1:0] CMD_CNT,
    input  logic [0:3]       CMD_DATA,
    input  logic [0:3]       Q,
    output logic [1:0]       S,
    output logic [1:0]       D,
    output logic [0:3]       IN,
    output logic             BUSY,
    output logic             DONE
);

    state_t           state_reg, state_next;
    logic [1:0]       s_reg,     s_next;
    logic [1:0]       d_reg,     d_next;
    logic [0:3]       in_reg,    in_next;
    logic             busy_reg,  busy_next;
    logic             done_reg,  done_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;
`ifdef SEQ_ROTATE_EN
    logic             rot_reg,   rot_next;
`endif

    always_ff @(posedge CLK or negedge MR_N) begin
        if (!MR_N) begin
            state_reg <= ST_IDLE;
            s_reg     <= S_HOLD;
            d_reg     <= '0;
            in_reg    <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            cnt_reg   <= '0;
`ifdef SEQ_ROTATE_EN
            rot_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            d_reg     <= d_next;
            in_reg    <= in_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            cnt_reg   <= cnt_next;
`ifdef SEQ_ROTATE_EN
            rot_reg   <= rot_next;
`endif
        end
    end

    // Outputs are computed one cycle ahead so that S/D/IN/BUSY/DONE come
    // straight from flops.
    always_comb begin
        state_next = state_reg;
        s_next     = S_HOLD;
        d_next     = d_reg;
        in_next    = in_reg;
        done_next  = 1'b0;
        cnt_next   = cnt_reg;
`ifdef SEQ_ROTATE_EN
        rot_next   = rot_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                // CMD_READY is high throughout IDLE, so VALID alone completes
                // the handshake here.
                if (CMD_VALID) begin
                    case (CMD_OP)
                        OP_LOAD: begin
                            state_next = ST_LOAD;
                            s_next     = S_LOAD;
                            in_next    = CMD_DATA;
                        end
                        OP_SHR, OP_SHL: begin
                            if (CMD_CNT != '0) begin
                                state_next = ST_SHIFT;
                                s_next     = (CMD_OP == OP_SHR) ? S_SHR : S_SHL;
                                d_next     = {2{CMD_FILL}};
                                cnt_next   = CMD_CNT;
`ifdef SEQ_ROTATE_EN
                                rot_next   = 1'b0;
`endif
                            end else begin
                                state_next = ST_DONE;
                                done_next  = 1'b1;
                            end
                        end
                        default: begin
`ifdef SEQ_ROTATE_EN
                            if (CMD_CNT != '0) begin
                                state_next = ST_SHIFT;
                                s_next     = S_SHR;
                                d_next     = 2'b00;
                                cnt_next   = CMD_CNT;
                                rot_next   = 1'b1;
                            end else begin
                                state_next = ST_DONE;
                                done_next  = 1'b1;
                            end
`else
                            state_next = ST_DONE;
                            done_next  = 1'b1;
`endif
                        end
                    endcase
                end
            end
            ST_LOAD: begin
                state_next = ST_DONE;
                done_next  = 1'b1;
            end
            ST_SHIFT: begin
                // The edge ending this cycle performs one register step.
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = ST_DONE;
                    done_next  = 1'b1;
                end else begin
                    s_next = s_reg;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    assign CMD_READY = (state_reg == ST_IDLE);
    assign S         = s_reg;
    assign IN        = in_reg;
    assign BUSY      = busy_reg;
    assign DONE      = done_reg;

`ifdef SEQ_ROTATE_EN
    // Rotate feeds the bit leaving OUT[3] back into the right-shift input.
    assign D = (rot_reg && state_reg == ST_SHIFT) ? {Q[3], d_reg[0]} : d_reg;
`else
    assign D = d_reg;
    logic q_unused;
    assign q_unused = ^Q;
`endif

endmodule

// File: tb/tb_w_shift_seq.sv
module tb_w_shift_seq;
    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             MR_N;
    logic             CMD_VALID;
    logic             CMD_READY;
    logic [1:0]       CMD_OP;
    logic             CMD_FILL;
    logic [CNT_W-1:0] CMD_CNT;
    logic [0:3]       CMD_DATA;
    logic [0:3]       Q;
    logic [1:0]       S;
    logic [1:0]       D;
    logic [0:3]       IN;
    logic             BUSY;
    logic             DONE;

    always #5 CLK = ~CLK;

    w_shift_seq #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .MR_N(MR_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_FILL(CMD_FILL), .CMD_CNT(CMD_CNT),
        .CMD_DATA(CMD_DATA), .Q(Q), .S(S), .D(D), .IN(IN),
        .BUSY(BUSY), .DONE(DONE)
    );

    W_74HC194 sr (
        .CLK(CLK), .MR_N(MR_N), .S(S), .D(D), .IN(IN), .OUT(Q)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: expected register contents and last loaded IN.
    logic [0:3] q_model;
    logic [0:3] in_model;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One register step as described by the 74HC194 data sheet.
    function automatic logic [0:3] step(input logic [1:0] op, input logic fill,
                                        input logic [0:3] q);
        case (op)
            2'b01:   return {fill, q[0:2]};
            2'b10:   return {q[1:3], fill};
            2'b11:   return {q[3], q[0:2]};
            default: return q;
        endcase
    endfunction

    // Issue one command (caller sits at a negedge with the sequencer idle),
    // then check every cycle until it is idle again.
    task automatic run_cmd(input logic [1:0] op, input logic fill,
                           input logic [3:0] cnt, input logic [0:3] data,
                           input bit junk);
        int         steps;
        logic [1:0] mode;
        bit         rot_on;
`ifdef SEQ_ROTATE_EN
        rot_on = 1'b1;
`else
        rot_on = 1'b0;
`endif
        if (op == 2'b00) begin
            steps = 1;
            mode  = 2'b11;
        end else if (op == 2'b11 && !rot_on) begin
            steps = 0;
            mode  = 2'b00;
        end else begin
            steps = int'(cnt);
            mode  = (op == 2'b10) ? 2'b10 : 2'b01;
        end

        check("ready_idle", CMD_READY, 1);
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_FILL  = fill;
        CMD_CNT   = cnt;
        CMD_DATA  = data;
        @(posedge CLK);
        if (op == 2'b00) in_model = data;
        @(negedge CLK);

        for (int j = 0; j <= steps; j++) begin
            check("busy", BUSY, 1);
            check("ready_busy", CMD_READY, 0);
            check("done", DONE, (j == steps) ? 1 : 0);
            check("s", S, (j < steps) ? mode : 2'b00);
            check("q", Q, q_model);
            check("in", IN, in_model);
            if (j < steps && op == 2'b11)
                check("d_ror", D[1], q_model[3]);
            else if (j < steps && op != 2'b00)
                check("d_shift", D, {fill, fill});
            // Garbage on the command bus while busy must be ignored; the
            // source drops VALID in the DONE cycle so nothing is re-accepted.
            if (junk && j < steps) begin
                CMD_VALID = 1'($urandom);
                CMD_OP    = 2'($urandom);
                CMD_FILL  = 1'($urandom);
                CMD_CNT   = 4'($urandom);
                CMD_DATA  = 4'($urandom);
            end else begin
                CMD_VALID = 1'b0;
            end
            @(posedge CLK);
            if (j < steps) q_model = (op == 2'b00) ? data : step(op, fill, q_model);
            @(negedge CLK);
        end
        CMD_VALID = 1'b0;
        check("ready_after", CMD_READY, 1);
        check("busy_after", BUSY, 0);
        check("done_after", DONE, 0);
        check("q_after", Q, q_model);
        $display("txn op=%0d fill=%0d cnt=%0d data=%b -> q=%b (model %b)",
                 op, fill, cnt, data, Q, q_model);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s"}, S, 2'b00);
        check({tag, "_d"}, D, 2'b00);
        check({tag, "_in"}, IN, 4'b0000);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_done"}, DONE, 0);
        check({tag, "_ready"}, CMD_READY, 1);
        check({tag, "_q"}, Q, 4'b0000);
    endtask

    initial begin
        MR_N      = 1'b0;
        CMD_VALID = 1'b0;
        CMD_OP    = 2'b00;
        CMD_FILL  = 1'b0;
        CMD_CNT   = '0;
        CMD_DATA  = 4'b0000;
        q_model   = 4'b0000;
        in_model  = 4'b0000;

        @(negedge CLK);
        @(negedge CLK);
        check_reset_outputs("rst_held");
        MR_N = 1'b1;
        @(negedge CLK);
        check_reset_outputs("rst_released");

        // Directed scenarios
        run_cmd(2'b00, 1'b0, 4'd0, 4'b1010, 1'b0);   // load 1010
        run_cmd(2'b00, 1'b0, 4'd0, 4'b0000, 1'b0);   // clear via load
        run_cmd(2'b01, 1'b1, 4'd2, 4'b0000, 1'b0);   // shr 2 fill 1 -> 1100
        run_cmd(2'b00, 1'b0, 4'd0, 4'b1010, 1'b1);   // load 1010
        run_cmd(2'b10, 1'b0, 4'd3, 4'b1111, 1'b1);   // shl 3 fill 0 -> 0000
        run_cmd(2'b01, 1'b1, 4'd0, 4'b1111, 1'b0);   // zero-count shift
        run_cmd(2'b10, 1'b1, 4'd0, 4'b0101, 1'b0);
        run_cmd(2'b00, 1'b0, 4'd0, 4'b1000, 1'b0);   // load 1000
        run_cmd(2'b11, 1'b0, 4'd4, 4'b0000, 1'b1);   // rotate 4 (or no-op)
        run_cmd(2'b11, 1'b1, 4'd3, 4'b0000, 1'b0);
        run_cmd(2'b11, 1'b0, 4'd0, 4'b0000, 1'b0);

        // Reset in the middle of a 15-step shift
        CMD_VALID = 1'b1;
        CMD_OP    = 2'b01;
        CMD_FILL  = 1'b1;
        CMD_CNT   = 4'd15;
        @(posedge CLK);
        @(negedge CLK);
        CMD_VALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            q_model = step(2'b01, 1'b1, q_model);
            @(negedge CLK);
        end
        check("mid_q_before_reset", Q, q_model);
        check("mid_busy_before_reset", BUSY, 1);
        MR_N = 1'b0;
        #1;
        q_model  = 4'b0000;
        in_model = 4'b0000;
        check_reset_outputs("mid_rst");
        @(negedge CLK);
        MR_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("post_rst_no_done", DONE, 0);
            check("post_rst_ready", CMD_READY, 1);
            check("post_rst_q", Q, 4'b0000);
        end
        run_cmd(2'b00, 1'b0, 4'd0, 4'b0110, 1'b0);
        run_cmd(2'b10, 1'b1, 4'd2, 4'b0000, 1'b0);

        // Randomized commands with idle gaps
        for (int n = 0; n < 40; n++) begin
            logic [1:0] op;
            logic [3:0] cnt;
            int gap;
            op  = 2'($urandom_range(0, 3));
            cnt = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 6));
            run_cmd(op, 1'($urandom), cnt, 4'($urandom), 1'($urandom));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge CLK);
                check("gap_ready", CMD_READY, 1);
                check("gap_s", S, 2'b00);
                check("gap_q", Q, q_model);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/w_shift_seq.md
# w_shift_seq

Command sequencer sitting directly upstream of the W_74HC194 universal shift register stage. Accepts one command per valid/ready handshake (parallel load, or N-step left/right shift with a chosen fill bit) and drives the register's mode (S), serial (D) and parallel (IN) inputs cycle by cycle. Reports completion with a one-cycle pulse. Reads the register's outputs back for rotate operation.

## Interface
- CNT_W, 4, width of shift-count field; max shift count 2^CNT_W-1
- CLK  in  1  clock, rising edge
- MR_N  in  1  asynchronous active-low reset, shared with the W_74HC194 stage
- CMD_VALID  in  1  command present
- CMD_READY  out  1  sequencer can accept a command (high only in IDLE)
- CMD_OP  in  2  00 load, 01 shift right, 10 shift left, 11 rotate right (see Configuration)
- CMD_FILL  in  1  serial fill bit for shift ops
- CMD_CNT  in  CNT_W  number of shift steps
- CMD_DATA  in  [0:3]  parallel load value
- Q  in  [0:3]  W_74HC194 OUT feedback
- S  out  2  mode to W_74HC194
- D  out  2  serial inputs to W_74HC194 (D[1] right-shift in, D[0] left-shift in)
- IN  out  [0:3]  parallel data to W_74HC194
- BUSY  out  1  command in progress
- DONE  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- Reset (MR_N low, any state): state IDLE; S=00, D=00, IN=0000, BUSY=0, DONE=0, counter=0, latched fields=0; CMD_READY=1.
- IDLE: S=00 (hold). Handshake when CMD_VALID & CMD_READY at a rising edge; fields latched on that edge. CMD_VALID without READY is ignored; command must be held by source.
- Op 00 -> LOAD for one cycle: S=11, IN=latched CMD_DATA; then DONE.
- Op 01/10 with CMD_CNT>0 -> SHIFT: S=01 (right) or 10 (left); D={fill,fill}; counter loaded with CMD_CNT, decremented each SHIFT cycle; leave SHIFT after the cycle where counter==1.
- Op 01/10 with CMD_CNT=0 -> DONE directly; S stays 00, register untouched.
- DONE: S=00, DONE=1 for exactly one cycle, then IDLE.
- BUSY=1 in LOAD, SHIFT, DONE.
- IN holds last loaded value outside LOAD (irrelevant to register since S≠11).

## Timing
- Accept at edge k. Load: S=11 during cycle k..k+1, Q updated at edge k+1, DONE high cycle after, READY at edge k+2.
- Shift count N≥1: S active for N cycles after edge k; Q completes at edge k+N; DONE high between edges k+N and k+N+1; READY at k+N+1. Total latency N+1 cycles accept-to-DONE.
- No back-to-back accept: minimum one DONE cycle between commands.
- S, D, IN, BUSY, DONE are registered; CMD_READY decoded from state only. Rotate D is combinational from Q (see below).
- Reset mid-operation: immediate return to IDLE, no DONE pulse, command lost.

## Configuration
- SEQ_ROTATE_EN defined: op 11 runs SHIFT with S=01 and D[1]=Q[3] each cycle (rotate right, N steps, CMD_FILL ignored); CMD_CNT=0 behaves as shift.
- Not defined: op 11 is a no-op: accepted, S stays 00, DONE after one cycle; Q input unused.

## Structure
- Package w_shift_seq_pkg: op codes (OP_LOAD, OP_SHR, OP_SHL, OP_ROR), mode constants for S (HOLD=00, SHR=01, SHL=10, LOAD=11), state enum.
- Single module; counter is inline, no sub-module.
- Bench instantiates W_74HC194 as the downstream load, same CLK/MR_N.

## Test plan
- Load 1010 -> S=11 one cycle, Q=1010, DONE pulse 2 cycles after accept, READY back.
- From Q=0000, shift right N=2 fill 1 -> Q 1000 then 1100; DONE at cycle 3.
- From Q=1010, shift left N=3 fill 0 -> Q 0100, 1000, 0000; exactly 3 cycles S=10.
- Shift N=0 -> Q unchanged, S never leaves 00, DONE one cycle after accept.
- With SEQ_ROTATE_EN, Q=1000 rotate N=4 -> 0100, 0010, 0001, 1000; without macro Q stays 1000.
- MR_N pulsed low during shift N=15 at step 5 -> Q=0000, outputs at reset values, no DONE, READY=1, next command accepted normally.
